uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 15 +
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/uart_tx_arbiter_tx.sv | 102 ++++++++++
 rtl/uart_tx_arbiter.sv | 73 +++++++
 tb/tb_uart_tx_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Valid/ready byte handshake for the two requesters feeding the UART arbiter.
// The master modport is the requester side, the slave modport is the arbiter.
interface uart_tx_arbiter_if;
    import uart_arb_pkg::*;

    logic                 req0_valid;
    logic [DATA_BITS-1:0] req0_data;
    logic                 req0_ready;
    logic                 req1_valid;
    logic [DATA_BITS-1:0] req1_data;
    logic                 req1_ready;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready
    );

endinterface

// File: rtl/uart_tx_arbiter_tx.sv
// UART serializer: baud counter, shift register and frame FSM.
// A byte presented with load while idle is latched and sent as
// start bit, eight data bits LSB first, stop bit; every bit lasts BAUD_DIV cycles.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | line high, waiting for load
// START   | driving the start bit
// DATA    | driving data bit bit_cnt (LSB first)
// STOP    | driving the stop bit; returns to IDLE on the last cycle
module uart_tx
    import uart_arb_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic                 CLOCK_100,
    input  logic                 nRESET,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data,
    output logic                 busy,
    output logic                 txd
);

    localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    tx_state_t            state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 baud_tick;

    assign baud_tick = (baud_cnt == BAUD_LAST);

    // Frame sequencer; busy and txd are registered so the line never glitches from inputs.
    always_ff @(posedge CLOCK_100 or negedge nRESET) begin
        if (!nRESET) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            busy     <= 1'b0;
            txd      <= STOP_BIT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        shreg    <= data;
                        state    <= ST_START;
                        txd      <= START_BIT;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        state    <= ST_DATA;
                        txd      <= shreg[0];
                        shreg    <= {1'b1, shreg[DATA_BITS-1:1]};
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= ST_STOP;
                            txd     <= STOP_BIT;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            txd     <= shreg[0];
                            shreg   <= {1'b1, shreg[DATA_BITS-1:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    txd   <= STOP_BIT;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmit arbiter: picks one byte at a time from the CPU
// port (requester 0) or the debug/trace source (requester 1) and hands it to
// the serializer. Ties go to requester 0 unless UART_ARB_RR_EN is defined,
// in which case a tie goes to the requester not granted last.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic               CLOCK_100,
    input  logic               nRESET,
    uart_tx_arbiter_if.slave   req,
    output logic               grant_id,
    output logic               busy,
    output logic               UART_TXD
);

    logic                 prefer0;
    logic                 pick0;
    logic                 grant0;
    logic                 grant1;
    logic                 load;
    logic [DATA_BITS-1:0] load_data;

`ifdef UART_ARB_RR_EN
    logic rr_ptr;

    // Round-robin pointer: 1 favours requester 0; moves only when a byte is taken.
    always_ff @(posedge CLOCK_100 or negedge nRESET) begin
        if (!nRESET) begin
            rr_ptr <= 1'b1;
        end else if (load) begin
            rr_ptr <= grant1;
        end
    end

    assign prefer0 = rr_ptr;
`else
    assign prefer0 = 1'b1;
`endif

    // Readys are gated by nRESET so nothing is offered while reset is held,
    // yet the first edge after release can already accept a byte.
    assign pick0  = req.req0_valid & (~req.req1_valid | prefer0);
    assign grant0 = nRESET & ~busy & pick0;
    assign grant1 = nRESET & ~busy & req.req1_valid & ~pick0;
    assign load   = grant0 | grant1;

    assign req.req0_ready = grant0;
    assign req.req1_ready = grant1;
    assign load_data      = grant1 ? req.req1_data : req.req0_data;

    // grant_id follows each accepted byte and holds while idle.
    always_ff @(posedge CLOCK_100 or negedge nRESET) begin
        if (!nRESET) begin
            grant_id <= 1'b0;
        end else if (load) begin
            grant_id <= grant1;
        end
    end

    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .CLOCK_100 (CLOCK_100),
        .nRESET    (nRESET),
        .load      (load),
        .data      (load_data),
        .busy      (busy),
        .txd       (UART_TXD)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: instance A at BAUD_DIV=4, instance B at BAUD_DIV=2.
// Tie expectations follow UART_ARB_RR_EN when it is defined for the build.
module tb_uart_tx_arbiter;

    logic clk;
    logic rst_n;
    logic txd_a, busy_a, grant_a;
    logic txd_b, busy_b, grant_b;
    int   n_cmp;
    int   n_err;
    bit   rr_mode;

    uart_tx_arbiter_if ifa ();
    uart_tx_arbiter_if ifb ();

    uart_tx_arbiter #(.BAUD_DIV(4)) dut_a (
        .CLOCK_100 (clk),
        .nRESET    (rst_n),
        .req       (ifa.slave),
        .grant_id  (grant_a),
        .busy      (busy_a),
        .UART_TXD  (txd_a)
    );

    uart_tx_arbiter #(.BAUD_DIV(2)) dut_b (
        .CLOCK_100 (clk),
        .nRESET    (rst_n),
        .req       (ifb.slave),
        .grant_id  (grant_b),
        .busy      (busy_b),
        .UART_TXD  (txd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples one whole frame starting at the first start-bit cycle, then the idle cycle after it.
    task automatic check_frame(input bit sel, input logic [7:0] b, input int div);
        logic [9:0] frame;
        logic       t, bz, rd;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < div; c++) begin
                t  = sel ? txd_b  : txd_a;
                bz = sel ? busy_b : busy_a;
                rd = sel ? (ifb.req0_ready | ifb.req1_ready) : (ifa.req0_ready | ifa.req1_ready);
                chk("frame_txd", t, frame[i]);
                chk("frame_busy", bz, 1);
                chk("frame_ready", rd, 0);
                tick();
            end
        end
        t  = sel ? txd_b  : txd_a;
        bz = sel ? busy_b : busy_a;
        chk("end_busy", bz, 0);
        chk("end_txd", t, 1);
    endtask

    initial begin
        logic expg;
        n_cmp = 0;
        n_err = 0;
`ifdef UART_ARB_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        rst_n = 1'b0;
        ifa.req0_valid = 1'b1; ifa.req0_data = 8'hA5;
        ifa.req1_valid = 1'b0; ifa.req1_data = 8'h00;
        ifb.req0_valid = 1'b0; ifb.req0_data = 8'h00;
        ifb.req1_valid = 1'b0; ifb.req1_data = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state, with a valid pending that must not be acknowledged.
        chk("rst_txd", txd_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_grant", grant_a, 0);
        chk("rst_ready0", ifa.req0_ready, 0);
        chk("rst_ready1", ifa.req1_ready, 0);
        chk("rst_txd_b", txd_b, 1);
        chk("rst_grant_b", grant_b, 0);

        // Single byte 0xA5 from requester 0, accepted on the first edge after release.
        rst_n = 1'b1;
        #1;
        chk("a5_ready0", ifa.req0_ready, 1);
        chk("a5_ready1", ifa.req1_ready, 0);
        tick();
        chk("a5_grant", grant_a, 0);
        chk("a5_ready0_after", ifa.req0_ready, 0);
        ifa.req0_valid = 1'b0;
        check_frame(1'b0, 8'hA5, 4);

        // Fresh reset so the round-robin pointer starts by favouring requester 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Tie: both requesters valid continuously for four frames.
        ifa.req0_valid = 1'b1; ifa.req0_data = 8'h11;
        ifa.req1_valid = 1'b1; ifa.req1_data = 8'h22;
        #1;
        for (int k = 0; k < 4; k++) begin
            expg = rr_mode ? logic'(k[0]) : 1'b0;
            chk("tie_ready0", ifa.req0_ready, !expg);
            chk("tie_ready1", ifa.req1_ready, expg);
            tick();
            chk("tie_grant", grant_a, expg);
            check_frame(1'b0, expg ? 8'h22 : 8'h11, 4);
        end
        ifa.req0_valid = 1'b0;
        ifa.req1_valid = 1'b0;
        tick();

        // Reset during data bit 3 of 0x96 (bit 3 is 0), then requester 1 sends 0x3C.
        ifa.req1_valid = 1'b1; ifa.req1_data = 8'h96;
        #1;
        chk("r96_ready1", ifa.req1_ready, 1);
        tick();
        ifa.req1_valid = 1'b0;
        repeat (17) tick();
        chk("bit3_txd", txd_a, 0);
        chk("bit3_busy", busy_a, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_txd", txd_a, 1);
        chk("midrst_busy", busy_a, 0);
        tick();
        rst_n = 1'b1;
        ifa.req1_valid = 1'b1; ifa.req1_data = 8'h3C;
        #1;
        chk("r3c_ready1", ifa.req1_ready, 1);
        chk("r3c_ready0", ifa.req0_ready, 0);
        tick();
        chk("r3c_grant", grant_a, 1);
        ifa.req1_valid = 1'b0;
        check_frame(1'b0, 8'h3C, 4);

        // Data stability: input byte changes right after acceptance.
        ifa.req1_valid = 1'b1; ifa.req1_data = 8'h55;
        #1;
        chk("r55_ready1", ifa.req1_ready, 1);
        tick();
        chk("r55_grant", grant_a, 1);
        ifa.req1_data  = 8'hFF;
        ifa.req1_valid = 1'b0;
        #1;
        check_frame(1'b0, 8'h55, 4);

        // BAUD_DIV=2: 0x00 then 0xFF back to back with a single idle cycle between.
        ifb.req0_valid = 1'b1; ifb.req0_data = 8'h00;
        #1;
        chk("b2_ready0", ifb.req0_ready, 1);
        tick();
        chk("b2_grant", grant_b, 0);
        ifb.req0_data = 8'hFF;
        #1;
        check_frame(1'b1, 8'h00, 2);
        chk("b2_gap_ready0", ifb.req0_ready, 1);
        tick();
        ifb.req0_valid = 1'b0;
        #1;
        check_frame(1'b1, 8'hFF, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
